dmem_responder: RTL

Responder end of the processor's data-memory interface: answers `address_dmem`/`d_dmem`/`wren_dmem` requests with `q_dmem` one cycle later. It also provides a host load/dump port, so a bench or debug host can preload data memory before a run and stream its contents out afterwards without hierarchical peeking. It sits beside `skeleton_ta` in place of the behavioural dmem.

---
 rtl/dmem_responder_if.sv | 39 +++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Bus bundle between a data-memory requester/host and dmem_responder:
// processor read/write port plus host load/dump command and data channels.
interface dmem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address_dmem;
  logic [DATA_WIDTH-1:0] d_dmem;
  logic                  wren_dmem;
  logic [DATA_WIDTH-1:0] q_dmem;

  logic                  host_cmd_valid;
  logic                  host_cmd_ready;
  logic                  host_cmd_op;
  logic [ADDR_WIDTH-1:0] host_base;
  logic [ADDR_WIDTH:0]   host_len;

  logic                  host_wdata_valid;
  logic                  host_wdata_ready;
  logic [DATA_WIDTH-1:0] host_wdata;

  logic                  host_rdata_valid;
  logic                  host_rdata_ready;
  logic [DATA_WIDTH-1:0] host_rdata;

  modport master (
    output address_dmem, d_dmem, wren_dmem,
    output host_cmd_valid, host_cmd_op, host_base, host_len,
    output host_wdata_valid, host_wdata, host_rdata_ready,
    input  q_dmem, host_cmd_ready, host_wdata_ready, host_rdata_valid, host_rdata
  );

  modport slave (
    input  address_dmem, d_dmem, wren_dmem,
    input  host_cmd_valid, host_cmd_op, host_base, host_len,
    input  host_wdata_valid, host_wdata, host_rdata_ready,
    output q_dmem, host_cmd_ready, host_wdata_ready, host_rdata_valid, host_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: read-first processor port with 1-cycle latency, plus a
// host engine that preloads (LOAD) or streams out (DUMP) a wrapped address range.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  dmem_responder_if.slave bus,
  output logic            busy,
  output logic            done,
  output logic [15:0]     dropped_writes
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_DONE
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         idx_q;
  logic                  cmd_ready_q;
  logic                  wdata_ready_q;
  logic                  rdata_valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] q_dmem_q;
  logic [15:0]           dropped_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  cmd_fire_c;
  logic                  wdata_fire_c;
  logic                  rdata_fire_c;
  logic                  last_c;
  logic                  proc_wr_c;
  logic [ADDR_WIDTH-1:0] host_addr_c;
  logic [LW-1:0]         len_clamped_c;

  always_comb begin
    cmd_fire_c    = bus.host_cmd_valid & cmd_ready_q;
    wdata_fire_c  = bus.host_wdata_valid & wdata_ready_q;
    rdata_fire_c  = rdata_valid_q & bus.host_rdata_ready;
    last_c        = (idx_q == (len_q - LW'(1)));
    proc_wr_c     = bus.wren_dmem & ~busy_q;
    host_addr_c   = base_q + idx_q[ADDR_WIDTH-1:0];
    len_clamped_c = (bus.host_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.host_len;
  end

  // Storage is never reset; host writes only happen in LOAD, when processor writes are dropped.
  always_ff @(posedge clock) begin
    if (wdata_fire_c) begin
      mem[host_addr_c] <= bus.host_wdata;
    end else if (proc_wr_c) begin
      mem[bus.address_dmem] <= bus.d_dmem;
    end
  end

  // Processor read path and dropped-write counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_dmem_q  <= '0;
      dropped_q <= '0;
    end else begin
      q_dmem_q <= mem[bus.address_dmem];
      if (bus.wren_dmem && busy_q && (dropped_q != 16'hFFFF)) begin
        dropped_q <= dropped_q + 16'd1;
      end
    end
  end

  // Host engine; handshake/status flags are updated alongside each state transition.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      cmd_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rdata_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_fire_c) begin
            base_q      <= bus.host_base;
            len_q       <= len_clamped_c;
            idx_q       <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (len_clamped_c == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (bus.host_cmd_op) begin
              state_q <= S_DUMP_RD;
            end else begin
              state_q       <= S_LOAD;
              wdata_ready_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (wdata_fire_c) begin
            idx_q <= idx_q + LW'(1);
            if (last_c) begin
              state_q       <= S_DONE;
              wdata_ready_q <= 1'b0;
              done_q        <= 1'b1;
            end
          end
        end
        S_DUMP_RD: begin
          rdata_q       <= mem[host_addr_c];
          rdata_valid_q <= 1'b1;
          state_q       <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (rdata_fire_c) begin
            idx_q         <= idx_q + LW'(1);
            rdata_valid_q <= 1'b0;
            if (last_c) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DUMP_RD;
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q       <= S_IDLE;
          cmd_ready_q   <= 1'b1;
          wdata_ready_q <= 1'b0;
          rdata_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          done_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q_dmem           = q_dmem_q;
  assign bus.host_cmd_ready   = cmd_ready_q;
  assign bus.host_wdata_ready = wdata_ready_q;
  assign bus.host_rdata_valid = rdata_valid_q;
  assign bus.host_rdata       = rdata_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign dropped_writes       = dropped_q;

endmodule
